ssd_debug_display: RTL

Seven-segment scan driver that consumes the processor top's debug outputs (`PC_out`, `Reg_out`) and shows a selected 16-bit half of one of them on a 4-digit common-anode display. It sits beside the CPU top on the board wrapper. It does the following:
- synchronises the selector switches;
- snapshots the value on a load strobe or a selector change;
- time-multiplexes the four hex digits.

---
 rtl/ssd_pkg.sv | 27 ++
 rtl/hex_to_ssd.sv | 11 +
 rtl/ssd_debug_display.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment debug display: segment table,
// blank pattern, digit states and selector encodings.
package ssd_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SSD_HEX [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SSD_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        D0 = 2'd0,
        D1 = 2'd1,
        D2 = 2'd2,
        D3 = 2'd3
    } ssd_digit_t;

    localparam logic [1:0] SEL_PC_LO  = 2'b00;
    localparam logic [1:0] SEL_PC_HI  = 2'b01;
    localparam logic [1:0] SEL_REG_LO = 2'b10;
    localparam logic [1:0] SEL_REG_HI = 2'b11;

endpackage

// File: rtl/hex_to_ssd.sv
// Combinational nibble to active-low seven-segment pattern.
module hex_to_ssd
    import ssd_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = SSD_HEX[i_nib];

endmodule

// File: rtl/ssd_debug_display.sv
// Four-digit hex scan driver for the CPU debug bus (PC / register value).
// Define SSD_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module ssd_debug_display
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] reg_in,
    input  logic [1:0]  sel,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [1:0]    r_sel_m;
    logic [1:0]    r_sel_s;
    logic [1:0]    r_sel_p;
    logic [15:0]   r_snap;
    logic [CW-1:0] r_cnt;
    ssd_digit_t    r_digit;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_chg;
    logic [15:0]   w_half;
    logic          w_wrap;
    ssd_digit_t    w_digit_nx;
    logic [3:0]    w_nib;
    logic [3:0]    w_an_on;
    logic [6:0]    w_seg;
    logic          w_blank;
    logic          w_dp_on;

    assign w_chg  = (r_sel_s != r_sel_p);
    assign w_wrap = (r_cnt == CNT_MAX);

    always_comb begin
        w_half = pc_in[15:0];
        unique case (r_sel_s)
            SEL_PC_LO:  w_half = pc_in[15:0];
            SEL_PC_HI:  w_half = pc_in[31:16];
            SEL_REG_LO: w_half = reg_in[15:0];
            SEL_REG_HI: w_half = reg_in[31:16];
        endcase
    end

    always_comb begin
        w_digit_nx = D0;
        w_nib      = r_snap[3:0];
        w_an_on    = 4'b1110;
        w_blank    = 1'b0;
        unique case (r_digit)
            D0: begin
                w_digit_nx = D1;
                w_nib      = r_snap[3:0];
                w_an_on    = 4'b1110;
            end
            D1: begin
                w_digit_nx = D2;
                w_nib      = r_snap[7:4];
                w_an_on    = 4'b1101;
`ifdef SSD_LEADING_ZERO_BLANK_EN
                w_blank    = (r_snap[15:4] == 12'h000);
`endif
            end
            D2: begin
                w_digit_nx = D3;
                w_nib      = r_snap[11:8];
                w_an_on    = 4'b1011;
`ifdef SSD_LEADING_ZERO_BLANK_EN
                w_blank    = (r_snap[15:8] == 8'h00);
`endif
            end
            D3: begin
                w_digit_nx = D0;
                w_nib      = r_snap[15:12];
                w_an_on    = 4'b0111;
`ifdef SSD_LEADING_ZERO_BLANK_EN
                w_blank    = (r_snap[15:12] == 4'h0);
`endif
            end
        endcase
    end

    // dp marks the upper half on D3 and keeps that anode on even if blanked
    assign w_dp_on = (r_digit == D3) && r_sel_s[0];

    hex_to_ssd u_hex (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sel_m <= 2'b00;
            r_sel_s <= 2'b00;
            r_sel_p <= 2'b00;
            r_snap  <= 16'h0000;
        end else begin
            r_sel_m <= sel;
            r_sel_s <= r_sel_m;
            r_sel_p <= r_sel_s;
            if (load || w_chg) begin
                r_snap <= w_half;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_digit <= D0;
        end else if (w_wrap) begin
            r_cnt   <= '0;
            r_digit <= w_digit_nx;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_an  <= 4'hF;
            r_seg <= SSD_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= (w_blank && !w_dp_on) ? 4'hF : w_an_on;
            r_seg <= w_blank ? SSD_BLANK : w_seg;
            r_dp  <= ~w_dp_on;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
